vx_cache_bank_arb: RTL and testbench
====================================

VX_CACHE_BANK_ARB -- requirements
Module: VX_cache_bank_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of core requesters.
REQ-002 SHALL have parameter NUM_BANKS, default 2: number of cache banks; power of two, at most NUM_REQS.
REQ-003 SHALL have parameter LINE_SIZE, default 16: line size in bytes.
REQ-004 SHALL have parameter WORD_SIZE, default 4: word size in bytes.
REQ-005 SHALL have parameter ADDR_WIDTH, default 30: word address width.
REQ-006 SHALL have parameter TAG_WIDTH, default 8: core request tag width.
REQ-007 SHALL have parameter STARVE_LIMIT, default 4: wait cycles before a requester becomes urgent; at least 1.
REQ-008 SHALL have parameter PERF_CTR_BITS, default 44: width of the stall counter.
REQ-009 One clock; reset is asynchronous and active-high.
REQ-010 clk  in  1  clock.
REQ-011 reset  in  1  asynchronous active-high reset.
REQ-012 core_req_valid  in  NUM_REQS  per-requester valid.
REQ-013 core_req_rw  in  NUM_REQS  1 = write.
REQ-014 core_req_addr  in  NUM_REQS x ADDR_WIDTH  word address.
REQ-015 core_req_byteen  in  NUM_REQS x WORD_SIZE  byte enables.
REQ-016 core_req_data  in  NUM_REQS x WORD_SIZE*8  write data.
REQ-017 core_req_tag  in  NUM_REQS x TAG_WIDTH  request tag.
REQ-018 core_req_ready  out  NUM_REQS  request accepted this cycle.
REQ-019 bank_req_valid  out  NUM_BANKS  per-bank request valid.
REQ-020 bank_req_rw, bank_req_byteen, bank_req_data, bank_req_tag  out  per bank, widths as the core fields  registered payload.
REQ-021 bank_req_addr  out  NUM_BANKS x LINE_ADDR_WIDTH  line address.
REQ-022 bank_req_wsel  out  NUM_BANKS x UP(WORD_SEL_BITS)  word select.
REQ-023 bank_req_idx  out  NUM_BANKS x UP(clog2 NUM_REQS)  index of the source requester.
REQ-024 bank_req_ready  in  NUM_BANKS  bank accepts its request.
REQ-025 bank_stalls  out  PERF_CTR_BITS  cumulative count of requester-cycles spent waiting.

Function
REQ-026 Address decode: wsel = addr[WORD_SEL_BITS-1:0]; bank id = addr[WORD_SEL_BITS +: BANK_SEL_BITS], or 0 when NUM_BANKS=1; line addr = remaining upper bits.
REQ-027 Each bank SHALL own a one-entry output register (valid_q plus payload), loadable when !valid_q or bank_req_ready; drain and reload in the same cycle SHALL give one request per cycle per bank.
REQ-028 A requester is eligible for bank b when its valid is high and its bank id equals b.
REQ-029 When a bank is loadable and has eligible requesters, it SHALL grant exactly one; core_req_ready is 1 only for granted requesters, so core_req_ready is combinational on this cycle's inputs and state.
REQ-030 Latency SHALL be 1 cycle: a request granted at edge N appears on bank_req_* after edge N.
REQ-031 Round-robin: each bank SHALL hold pointer ptr[b] (0..NUM_REQS-1); the search starts at ptr[b] and wraps modulo NUM_REQS; after granting r, ptr[b] becomes (r+1) mod NUM_REQS, wrapping from NUM_REQS-1 to 0.
REQ-032 Aging: per requester age[r], width clog2(STARVE_LIMIT+1); +1 per cycle while valid and not ready, saturating at STARVE_LIMIT; cleared on grant or when not valid.
REQ-033 If any eligible requester of bank b has age == STARVE_LIMIT, the lowest-indexed such requester SHALL win over round-robin, and ptr[b] SHALL update per REQ-031.
REQ-034 Requesters that do not hold stable payload while valid and not ready are a protocol violation; the block does not detect it.
REQ-035 bank_stalls SHALL add popcount(core_req_valid & ~core_req_ready) every cycle, wrapping on overflow.
REQ-036 While bank_req_valid=1 and bank_req_ready=0, the bank payload SHALL stay unchanged.

Reset
REQ-037 Reset assertion SHALL immediately (no clock edge): clear all valid_q, ptr, age and bank_stalls, and force core_req_ready and bank_req_valid to 0.
REQ-038 After reset deasserts, arbitration SHALL begin on the first clock edge; payload registers need no reset.

Structure
REQ-039 Package VX_cache_pkg SHALL hold the bank/word-select and line-address width helpers and the request payload struct (rw, addr, wsel, byteen, data, tag, idx).
REQ-040 Sub-module VX_cache_bank_arb_slice, instantiated once per bank, SHALL contain one bank's pointer, priority select and output register; aging and stall counting stay at top level.

Verification (NUM_REQS=4, NUM_BANKS=2, LINE_SIZE=16, WORD_SIZE=4, STARVE_LIMIT=2)
REQ-041 Assert reset mid-traffic with bank_req_valid=1 -> bank_req_valid=0 and core_req_ready=0 before the next edge; first grant after release starts from ptr=0.
REQ-042 Requesters 0 and 2 continuously valid to bank 0, bank_req_ready=1 -> bank_req_idx[0] sequence 0,2,0,2; one grant per cycle.
REQ-043 Requester 0 addr 0x00 (bank 0), requester 1 addr 0x04 (bank 1), same cycle -> core_req_ready=4'b0011; both banks valid next cycle; wsel=0.
REQ-044 Bank 0 full with bank_req_ready=0, requester 0 waiting -> core_req_ready[0]=0 and payload held; bank_req_ready=1 -> drain and load requester 0 in the same cycle.
REQ-045 Bank 0 stalled 3 cycles with requester 3 waiting, ptr=0, requester 0 valid -> age[3]=2; on release requester 3 is granted first and ptr becomes 0.
REQ-046 Requesters 1 and 3 each wait 3 cycles -> bank_stalls increases by 6.

Source files
------------

// File: rtl/vx_cache_bank_arb_pkg.sv
// rtl/vx_cache_bank_arb_pkg.sv - width helpers and bank request payload shared by the cache bank arbiter
//
// Purpose: address-split width helpers (word select, bank select, line address)
//          and the reference bank request payload struct.
// Ports:   none (package).
package VX_cache_pkg;

  // Clamp a field width to at least one bit so zero-width selects stay legal.
  function automatic int up(input int x);
    return (x < 1) ? 1 : x;
  endfunction

  function automatic int word_sel_bits(input int line_size, input int word_size);
    return $clog2(line_size / word_size);
  endfunction

  function automatic int bank_sel_bits(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int line_addr_width(input int addr_width, input int line_size,
                                         input int word_size, input int num_banks);
    return addr_width - word_sel_bits(line_size, word_size) - bank_sel_bits(num_banks);
  endfunction

  // Payload layout for the default configuration (4 requesters, 2 banks,
  // 16B lines, 4B words, 30-bit word address, 8-bit tag). The arbiter builds
  // an identically named struct sized from its own parameters.
  localparam int DEF_LINE_AW = line_addr_width(30, 16, 4, 2);
  localparam int DEF_WSEL_W  = up(word_sel_bits(16, 4));
  localparam int DEF_IDX_W   = up($clog2(4));

  typedef struct packed {
    logic                   rw;
    logic [DEF_LINE_AW-1:0] addr;
    logic [DEF_WSEL_W-1:0]  wsel;
    logic [3:0]             byteen;
    logic [31:0]            data;
    logic [7:0]             tag;
    logic [DEF_IDX_W-1:0]   idx;
  } bank_req_t;

endpackage

// File: rtl/vx_cache_bank_arb_if.sv
// rtl/vx_cache_bank_arb_if.sv - core-side and bank-side request buses of the cache bank arbiter
//
// Purpose: bundles per-requester core request signals and per-bank request
//          signals.
// Modports:
//   master - drives core_req_* and bank_req_ready; observes core_req_ready,
//            bank_req_* and bank_stalls.
//   slave  - the arbiter side (mirror of master).
interface vx_cache_bank_arb_if
  import VX_cache_pkg::*;
#(
  parameter int NUM_REQS      = 4,
  parameter int NUM_BANKS     = 2,
  parameter int LINE_SIZE     = 16,
  parameter int WORD_SIZE     = 4,
  parameter int ADDR_WIDTH    = 30,
  parameter int TAG_WIDTH     = 8,
  parameter int PERF_CTR_BITS = 44
);
  localparam int LINE_AW = line_addr_width(ADDR_WIDTH, LINE_SIZE, WORD_SIZE, NUM_BANKS);
  localparam int WSEL_W  = up(word_sel_bits(LINE_SIZE, WORD_SIZE));
  localparam int IDX_W   = up($clog2(NUM_REQS));

  logic [NUM_REQS-1:0]                      core_req_valid;
  logic [NUM_REQS-1:0]                      core_req_rw;
  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]      core_req_addr;
  logic [NUM_REQS-1:0][WORD_SIZE-1:0]       core_req_byteen;
  logic [NUM_REQS-1:0][WORD_SIZE*8-1:0]     core_req_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]       core_req_tag;
  logic [NUM_REQS-1:0]                      core_req_ready;

  logic [NUM_BANKS-1:0]                     bank_req_valid;
  logic [NUM_BANKS-1:0]                     bank_req_rw;
  logic [NUM_BANKS-1:0][LINE_AW-1:0]        bank_req_addr;
  logic [NUM_BANKS-1:0][WSEL_W-1:0]         bank_req_wsel;
  logic [NUM_BANKS-1:0][WORD_SIZE-1:0]      bank_req_byteen;
  logic [NUM_BANKS-1:0][WORD_SIZE*8-1:0]    bank_req_data;
  logic [NUM_BANKS-1:0][TAG_WIDTH-1:0]      bank_req_tag;
  logic [NUM_BANKS-1:0][IDX_W-1:0]          bank_req_idx;
  logic [NUM_BANKS-1:0]                     bank_req_ready;

  logic [PERF_CTR_BITS-1:0]                 bank_stalls;

  modport master (
    output core_req_valid, core_req_rw, core_req_addr, core_req_byteen,
           core_req_data, core_req_tag, bank_req_ready,
    input  core_req_ready, bank_req_valid, bank_req_rw, bank_req_addr,
           bank_req_wsel, bank_req_byteen, bank_req_data, bank_req_tag,
           bank_req_idx, bank_stalls
  );

  modport slave (
    input  core_req_valid, core_req_rw, core_req_addr, core_req_byteen,
           core_req_data, core_req_tag, bank_req_ready,
    output core_req_ready, bank_req_valid, bank_req_rw, bank_req_addr,
           bank_req_wsel, bank_req_byteen, bank_req_data, bank_req_tag,
           bank_req_idx, bank_stalls
  );

endinterface

// File: rtl/vx_cache_bank_arb_slice.sv
// rtl/vx_cache_bank_arb_slice.sv - one bank's round-robin pointer, priority select and output register
//
// Purpose: picks one eligible requester per cycle for a single bank (urgent
//          requesters first, otherwise round-robin from r_ptr) and holds the
//          chosen payload in a one-entry output register.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   i_eligible    - requesters targeting this bank with valid high
//   i_urgent      - requesters whose age reached the starvation limit
//   i_payload     - per-requester decoded payload
//   i_bank_ready  - bank accepts the registered request
//   o_grant       - one-hot grant (zero while reset is asserted)
//   o_valid       - registered request valid
//   o_payload     - registered request payload
module VX_cache_bank_arb_slice #(
  parameter int  NUM_REQS  = 4,
  parameter int  IDX_W     = 2,
  parameter type payload_t = VX_cache_pkg::bank_req_t
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQS-1:0]     i_eligible,
  input  logic [NUM_REQS-1:0]     i_urgent,
  input  payload_t [NUM_REQS-1:0] i_payload,
  input  logic                    i_bank_ready,
  output logic [NUM_REQS-1:0]     o_grant,
  output logic                    o_valid,
  output payload_t                o_payload
);

  logic             r_valid;
  logic [IDX_W-1:0] r_ptr;
  payload_t         r_payload;

  logic             w_load;
  logic             w_found;
  logic [IDX_W-1:0] w_sel;

  // The register can take a new entry when empty or when it drains this cycle.
  assign w_load = !r_valid || i_bank_ready;

  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_REQS) j = j - NUM_REQS;
      if (!w_found && i_eligible[IDX_W'(j)]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(j);
      end
    end
    // Downward scan so the lowest-indexed urgent requester ends up selected.
    for (int r = NUM_REQS - 1; r >= 0; r--) begin
      if (i_eligible[r] && i_urgent[r]) w_sel = IDX_W'(r);
    end
  end

  always_comb begin
    o_grant = '0;
    if (!reset && w_load && w_found) o_grant[w_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= w_found;
      if (w_found) begin
        r_ptr <= (w_sel == IDX_W'(NUM_REQS - 1)) ? '0 : w_sel + 1'b1;
      end
    end
  end

  // Payload only moves when a new request is captured, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (w_load && w_found) r_payload <= i_payload[w_sel];
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;

endmodule

// File: rtl/vx_cache_bank_arb.sv
// rtl/vx_cache_bank_arb.sv - routes core requests to cache banks with round-robin and anti-starvation arbitration
//
// Purpose: decodes each core request address into bank / word select / line
//          address, arbitrates per bank through one slice per bank, ages
//          waiting requesters and counts stalled requester-cycles.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   bus        - vx_cache_bank_arb_if.slave (core_req_*, bank_req_*, bank_stalls)
module vx_cache_bank_arb
  import VX_cache_pkg::*;
#(
  parameter int NUM_REQS      = 4,
  parameter int NUM_BANKS     = 2,
  parameter int LINE_SIZE     = 16,
  parameter int WORD_SIZE     = 4,
  parameter int ADDR_WIDTH    = 30,
  parameter int TAG_WIDTH     = 8,
  parameter int STARVE_LIMIT  = 4,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                clk,
  input  logic                reset,
  vx_cache_bank_arb_if.slave  bus
);

  localparam int WSB     = word_sel_bits(LINE_SIZE, WORD_SIZE);
  localparam int BSB     = bank_sel_bits(NUM_BANKS);
  localparam int WSEL_W  = up(WSB);
  localparam int BSEL_W  = up(BSB);
  localparam int LINE_AW = line_addr_width(ADDR_WIDTH, LINE_SIZE, WORD_SIZE, NUM_BANKS);
  localparam int IDX_W   = up($clog2(NUM_REQS));
  localparam int AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W   = $clog2(NUM_REQS + 1);

  typedef struct packed {
    logic                   rw;
    logic [LINE_AW-1:0]     addr;
    logic [WSEL_W-1:0]      wsel;
    logic [WORD_SIZE-1:0]   byteen;
    logic [WORD_SIZE*8-1:0] data;
    logic [TAG_WIDTH-1:0]   tag;
    logic [IDX_W-1:0]       idx;
  } req_t;

  logic [NUM_REQS-1:0][BSEL_W-1:0]   w_bank_id;
  req_t [NUM_REQS-1:0]               w_req;
  logic [NUM_BANKS-1:0][NUM_REQS-1:0] w_elig;
  logic [NUM_BANKS-1:0][NUM_REQS-1:0] w_grant;
  logic [NUM_REQS-1:0]               w_urgent;
  logic [NUM_REQS-1:0]               w_ready;
  logic [CNT_W-1:0]                  w_stall_cnt;

  logic [NUM_REQS-1:0][AGE_W-1:0]    r_age;
  logic [PERF_CTR_BITS-1:0]          r_stalls;

  for (genvar r = 0; r < NUM_REQS; r++) begin : g_decode
    logic [WSEL_W-1:0] w_wsel;

    if (WSB > 0) begin : g_wsel
      assign w_wsel = bus.core_req_addr[r][WSEL_W-1:0];
    end else begin : g_no_wsel
      assign w_wsel = '0;
    end

    if (BSB > 0) begin : g_bsel
      assign w_bank_id[r] = bus.core_req_addr[r][WSB +: BSEL_W];
    end else begin : g_no_bsel
      assign w_bank_id[r] = '0;
    end

    assign w_req[r] = '{
      rw:     bus.core_req_rw[r],
      addr:   bus.core_req_addr[r][ADDR_WIDTH-1 : WSB + BSB],
      wsel:   w_wsel,
      byteen: bus.core_req_byteen[r],
      data:   bus.core_req_data[r],
      tag:    bus.core_req_tag[r],
      idx:    IDX_W'(r)
    };

    assign w_urgent[r] = (r_age[r] == AGE_W'(STARVE_LIMIT));
  end

  always_comb begin
    w_elig = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int r = 0; r < NUM_REQS; r++) begin
        w_elig[b][r] = bus.core_req_valid[r] && (w_bank_id[r] == BSEL_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    req_t w_out;

    VX_cache_bank_arb_slice #(
      .NUM_REQS  (NUM_REQS),
      .IDX_W     (IDX_W),
      .payload_t (req_t)
    ) u_slice (
      .clk          (clk),
      .reset        (reset),
      .i_eligible   (w_elig[b]),
      .i_urgent     (w_urgent),
      .i_payload    (w_req),
      .i_bank_ready (bus.bank_req_ready[b]),
      .o_grant      (w_grant[b]),
      .o_valid      (bus.bank_req_valid[b]),
      .o_payload    (w_out)
    );

    assign bus.bank_req_rw[b]     = w_out.rw;
    assign bus.bank_req_addr[b]   = w_out.addr;
    assign bus.bank_req_wsel[b]   = w_out.wsel;
    assign bus.bank_req_byteen[b] = w_out.byteen;
    assign bus.bank_req_data[b]   = w_out.data;
    assign bus.bank_req_tag[b]    = w_out.tag;
    assign bus.bank_req_idx[b]    = w_out.idx;
  end

  // Each requester targets exactly one bank, so OR-ing the bank grants is safe.
  always_comb begin
    w_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) w_ready = w_ready | w_grant[b];
  end

  assign bus.core_req_ready = w_ready;

  always_comb begin
    w_stall_cnt = '0;
    for (int r = 0; r < NUM_REQS; r++) begin
      if (bus.core_req_valid[r] && !w_ready[r]) w_stall_cnt = w_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_age <= '0;
    end else begin
      for (int r = 0; r < NUM_REQS; r++) begin
        if (!bus.core_req_valid[r] || w_ready[r]) begin
          r_age[r] <= '0;
        end else if (r_age[r] != AGE_W'(STARVE_LIMIT)) begin
          r_age[r] <= r_age[r] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stalls <= '0;
    else       r_stalls <= r_stalls + PERF_CTR_BITS'(w_stall_cnt);
  end

  assign bus.bank_stalls = r_stalls;

endmodule

// File: tb/tb_vx_cache_bank_arb.sv
// tb/tb_vx_cache_bank_arb.sv - self-checking bench for the cache bank arbiter
module tb_vx_cache_bank_arb;
  localparam int NR = 4;
  localparam int NB = 2;
  localparam int LS = 16;
  localparam int WS = 4;
  localparam int AW = 30;
  localparam int TW = 8;
  localparam int SL = 2;
  localparam int PB = 44;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_cache_bank_arb_if #(
    .NUM_REQS(NR), .NUM_BANKS(NB), .LINE_SIZE(LS), .WORD_SIZE(WS),
    .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .PERF_CTR_BITS(PB)
  ) bus ();

  vx_cache_bank_arb #(
    .NUM_REQS(NR), .NUM_BANKS(NB), .LINE_SIZE(LS), .WORD_SIZE(WS),
    .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .STARVE_LIMIT(SL), .PERF_CTR_BITS(PB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  int          m_valid [NB];
  int          m_ptr   [NB];
  int          m_gnt   [NB];
  int          m_rw    [NB];
  int          m_line  [NB];
  int          m_wsel  [NB];
  int          m_be    [NB];
  int          m_tag   [NB];
  int          m_idx   [NB];
  logic [31:0] m_data  [NB];
  int          m_age   [NR];
  logic [PB-1:0] m_stalls;
  logic [NR-1:0] exp_ready;

  int rr_seq [4];
  logic [PB-1:0] base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bank_of(input int a);
    return (a / 4) % 2;
  endfunction

  function automatic bit elig(input int r, input int b);
    return bus.core_req_valid[r] && (bank_of(int'(bus.core_req_addr[r])) == b);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_valid[b] = 0;
      m_ptr[b]   = 0;
      m_gnt[b]   = -1;
    end
    for (int r = 0; r < NR; r++) m_age[r] = 0;
    m_stalls  = '0;
    exp_ready = '0;
  endtask

  // Grants for this cycle: urgent lowest index first, else round-robin from ptr.
  task automatic model_comb();
    int c;
    exp_ready = '0;
    for (int b = 0; b < NB; b++) begin
      m_gnt[b] = -1;
      if (m_valid[b] == 0 || bus.bank_req_ready[b]) begin
        for (int r = 0; r < NR; r++)
          if (m_gnt[b] < 0 && elig(r, b) && m_age[r] == SL) m_gnt[b] = r;
        for (int k = 0; k < NR; k++) begin
          c = (m_ptr[b] + k) % NR;
          if (m_gnt[b] < 0 && elig(c, b)) m_gnt[b] = c;
        end
        if (m_gnt[b] >= 0) exp_ready[m_gnt[b]] = 1'b1;
      end
    end
  endtask

  task automatic model_seq();
    int n;
    int r;
    int a;
    n = 0;
    for (int i = 0; i < NR; i++) if (bus.core_req_valid[i] && !exp_ready[i]) n++;
    m_stalls = m_stalls + PB'(n);
    for (int i = 0; i < NR; i++) begin
      if (!bus.core_req_valid[i] || exp_ready[i]) m_age[i] = 0;
      else if (m_age[i] < SL) m_age[i] = m_age[i] + 1;
    end
    for (int b = 0; b < NB; b++) begin
      if (m_valid[b] == 0 || bus.bank_req_ready[b]) begin
        m_valid[b] = (m_gnt[b] >= 0) ? 1 : 0;
        if (m_gnt[b] >= 0) begin
          r = m_gnt[b];
          a = int'(bus.core_req_addr[r]);
          m_rw[b]   = int'(bus.core_req_rw[r]);
          m_line[b] = a / 8;
          m_wsel[b] = a % 4;
          m_be[b]   = int'(bus.core_req_byteen[r]);
          m_data[b] = bus.core_req_data[r];
          m_tag[b]  = int'(bus.core_req_tag[r]);
          m_idx[b]  = r;
          m_ptr[b]  = (r + 1) % NR;
        end
      end
    end
  endtask

  task automatic check_banks();
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("bank%0d_valid", b), 64'(bus.bank_req_valid[b]), 64'(m_valid[b] != 0));
      if (m_valid[b] != 0) begin
        chk($sformatf("bank%0d_rw", b),     64'(bus.bank_req_rw[b]),     64'(m_rw[b]));
        chk($sformatf("bank%0d_addr", b),   64'(bus.bank_req_addr[b]),   64'(m_line[b]));
        chk($sformatf("bank%0d_wsel", b),   64'(bus.bank_req_wsel[b]),   64'(m_wsel[b]));
        chk($sformatf("bank%0d_byteen", b), 64'(bus.bank_req_byteen[b]), 64'(m_be[b]));
        chk($sformatf("bank%0d_data", b),   64'(bus.bank_req_data[b]),   64'(m_data[b]));
        chk($sformatf("bank%0d_tag", b),    64'(bus.bank_req_tag[b]),    64'(m_tag[b]));
        chk($sformatf("bank%0d_idx", b),    64'(bus.bank_req_idx[b]),    64'(m_idx[b]));
      end
    end
    chk("bank_stalls", 64'(bus.bank_stalls), 64'(m_stalls));
  endtask

  // One clock: check combinational ready, take the edge, check registered state.
  task automatic step();
    #1;
    model_comb();
    chk("core_req_ready", 64'(bus.core_req_ready), 64'(exp_ready));
    @(posedge clk);
    model_seq();
    #1;
    check_banks();
  endtask

  task automatic drive(input int r, input bit v, input int a, input int tag);
    bus.core_req_valid[r]  = v;
    bus.core_req_addr[r]   = AW'(a);
    bus.core_req_tag[r]    = TW'(tag);
    bus.core_req_rw[r]     = 1'($urandom);
    bus.core_req_byteen[r] = 4'($urandom);
    bus.core_req_data[r]   = $urandom;
  endtask

  task automatic idle_all();
    for (int r = 0; r < NR; r++) bus.core_req_valid[r] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int r = 0; r < NR; r++) drive(r, 1'b0, 0, 0);
    bus.bank_req_ready = '0;
    rr_seq = '{0, 2, 0, 2};
    model_reset();

    #3;
    chk("reset_bank_valid", 64'(bus.bank_req_valid), 64'(0));
    chk("reset_core_ready", 64'(bus.core_req_ready), 64'(0));
    chk("reset_stalls",     64'(bus.bank_stalls),    64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Two requesters on bank 0 alternate one grant per cycle.
    bus.bank_req_ready = 2'b11;
    drive(0, 1'b1, 'h00, 'h01);
    drive(2, 1'b1, 'h10, 'h02);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr_idx%0d", i), 64'(bus.bank_req_idx[0]), 64'(rr_seq[i]));
    end
    idle_all();
    step();

    // Different banks in the same cycle are both granted.
    drive(0, 1'b1, 'h00, 'h0a);
    drive(1, 1'b1, 'h04, 'h0b);
    #1;
    chk("dual_ready", 64'(bus.core_req_ready), 64'(4'b0011));
    step();
    chk("dual_valid", 64'(bus.bank_req_valid), 64'(2'b11));
    chk("dual_wsel0", 64'(bus.bank_req_wsel[0]), 64'(0));
    chk("dual_wsel1", 64'(bus.bank_req_wsel[1]), 64'(0));
    idle_all();
    step();

    // Full bank holds its payload; drain and reload happen in one cycle.
    bus.bank_req_ready = 2'b00;
    drive(0, 1'b1, 'h20, 'h11);
    step();
    drive(0, 1'b1, 'h28, 'h22);
    #1;
    chk("full_hold_ready", 64'(bus.core_req_ready[0]), 64'(0));
    step();
    step();
    chk("held_tag", 64'(bus.bank_req_tag[0]), 64'(8'h11));
    bus.bank_req_ready = 2'b01;
    #1;
    chk("drain_load_ready", 64'(bus.core_req_ready[0]), 64'(1));
    step();
    chk("reload_tag", 64'(bus.bank_req_tag[0]), 64'(8'h22));
    idle_all();

    // Starved requester 3 beats round-robin pointer 0.
    drive(3, 1'b1, 'h18, 'h30);
    step();
    bus.bank_req_ready = 2'b00;
    drive(3, 1'b1, 'h38, 'h33);
    for (int i = 0; i < 3; i++) step();
    bus.bank_req_ready = 2'b01;
    drive(0, 1'b1, 'h00, 'h44);
    #1;
    chk("urgent_ready", 64'(bus.core_req_ready), 64'(4'b1000));
    step();
    chk("urgent_tag", 64'(bus.bank_req_tag[0]), 64'(8'h33));
    bus.core_req_valid[3] = 1'b0;
    #1;
    chk("after_urgent_ready", 64'(bus.core_req_ready), 64'(4'b0001));
    step();
    idle_all();

    // Two requesters waiting three cycles add six stall counts.
    bus.bank_req_ready = 2'b11;
    drive(1, 1'b1, 'h04, 'h51);
    drive(3, 1'b1, 'h18, 'h53);
    step();
    bus.bank_req_ready = 2'b00;
    drive(1, 1'b1, 'h0c, 'h61);
    drive(3, 1'b1, 'h18, 'h63);
    base = bus.bank_stalls;
    for (int i = 0; i < 3; i++) step();
    chk("stall_delta", 64'(bus.bank_stalls - base), 64'(6));

    // Reset in the middle of traffic clears outputs without a clock edge.
    bus.bank_req_ready = 2'b11;
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_bank_valid", 64'(bus.bank_req_valid), 64'(0));
    chk("midrst_core_ready", 64'(bus.core_req_ready), 64'(0));
    chk("midrst_stalls",     64'(bus.bank_stalls),    64'(0));
    @(posedge clk);
    #1;
    chk("midrst_hold_valid", 64'(bus.bank_req_valid), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    bus.core_req_valid[1] = 1'b0;
    drive(0, 1'b1, 'h00, 'h70);
    #1;
    chk("post_reset_ptr", 64'(bus.core_req_ready), 64'(4'b0001));
    step();

    // Random traffic with payloads held while a request waits.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < NR; r++) begin
        if (!(bus.core_req_valid[r] && !exp_ready[r])) begin
          drive(r, ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 63))
                                            : int'($urandom & 32'h3fff_ffff),
                int'($urandom_range(0, 255)));
        end
      end
      bus.bank_req_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
